// File: rtl/warp_pkg.sv
// Shared definitions for the warp memory path: datapath widths, the responder
// FSM state type and the responder's latency limit.
package warp_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int ADDR_WIDTH      = 32;
  localparam int RSP_LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    RSP_IDLE    = 2'd0,
    RSP_ACCESS  = 2'd1,
    RSP_RESPOND = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/lane_mem_sram.sv
// Behavioural scratchpad: asynchronous read, two synchronous write ports.
// When both write ports hit the same word, the access port wins.
module lane_mem_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                         clk,
  input  logic [$clog2(MEM_WORDS)-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]        rd_data,
  input  logic                         acc_we,
  input  logic [$clog2(MEM_WORDS)-1:0] acc_idx,
  input  logic [DATA_WIDTH-1:0]        acc_data,
  input  logic                         init_we,
  input  logic [$clog2(MEM_WORDS)-1:0] init_idx,
  input  logic [DATA_WIDTH-1:0]        init_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  assign rd_data = mem[rd_idx];

  // Contents are deliberately not reset; the later assignment gives the
  // access port priority on a same-word collision.
  always_ff @(posedge clk) begin
    if (init_we) mem[init_idx] <= init_data;
    if (acc_we)  mem[acc_idx]  <= acc_data;
  end

endmodule

// File: rtl/lane_mem_responder.sv
// Single-outstanding scratchpad responder with a fixed access latency.
// Optional statistics counters are enabled by defining LANE_MEM_RESPONDER_STATS_EN.
module lane_mem_responder
  import warp_pkg::*;
#(
  parameter int DATA_WIDTH = warp_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = warp_pkg::ADDR_WIDTH,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_req_valid,
  output logic                         mem_req_ready,
  input  logic [ADDR_WIDTH-1:0]        mem_req_addr,
  input  logic                         mem_req_write,
  input  logic [DATA_WIDTH-1:0]        mem_req_data,
  output logic                         mem_resp_valid,
  input  logic                         mem_resp_ready,
  output logic [DATA_WIDTH-1:0]        mem_resp_data,
  output logic                         mem_resp_err,
  input  logic                         init_we,
  input  logic [$clog2(MEM_WORDS)-1:0] init_idx,
  input  logic [DATA_WIDTH-1:0]        init_data,
  output logic [31:0]                  stat_rd_count,
  output logic [31:0]                  stat_wr_count,
  output logic [31:0]                  stat_err_count
);

  localparam int IDX_WIDTH = $clog2(MEM_WORDS);
  localparam int OFF_BITS  = $clog2(DATA_WIDTH / 8);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > RSP_LATENCY_MAX) begin : g_bad_latency
    $error("lane_mem_responder: LATENCY must be in 1..%0d", RSP_LATENCY_MAX);
  end
  if ((1 << IDX_WIDTH) != MEM_WORDS) begin : g_bad_depth
    $error("lane_mem_responder: MEM_WORDS must be a power of two");
  end

  rsp_state_e            state, next_state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  resp_err_q;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  fault;
  logic                  commit;
  logic                  acc_we;
  logic [DATA_WIDTH-1:0] rd_data;

  // The full word address is compared against the depth so that addresses
  // beyond the array fault rather than alias onto low words.
  assign word_addr = addr_q >> OFF_BITS;
  assign fault     = (addr_q[OFF_BITS-1:0] != '0) ||
                     (word_addr >= ADDR_WIDTH'(MEM_WORDS));
  assign commit    = (state == RSP_ACCESS) && (cnt == 4'd0);
  assign acc_we    = commit && write_q && !fault;

  lane_mem_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_sram (
    .clk       (clk),
    .rd_idx    (word_addr[IDX_WIDTH-1:0]),
    .rd_data   (rd_data),
    .acc_we    (acc_we),
    .acc_idx   (word_addr[IDX_WIDTH-1:0]),
    .acc_data  (wdata_q),
    .init_we   (init_we),
    .init_idx  (init_idx),
    .init_data (init_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RSP_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state     = state;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    case (state)
      RSP_IDLE: begin
        mem_req_ready = 1'b1;
        if (mem_req_valid) next_state = RSP_ACCESS;
      end
      RSP_ACCESS: begin
        if (cnt == 4'd0) next_state = RSP_RESPOND;
      end
      RSP_RESPOND: begin
        mem_resp_valid = 1'b1;
        if (mem_resp_ready) next_state = RSP_IDLE;
      end
      default: next_state = RSP_IDLE;
    endcase
  end

  // Request capture, latency countdown and response registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      if (state == RSP_IDLE && mem_req_valid) begin
        addr_q  <= mem_req_addr;
        write_q <= mem_req_write;
        wdata_q <= mem_req_data;
        cnt     <= CNT_INIT;
      end else if (state == RSP_ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        resp_data_q <= (write_q || fault) ? '0 : rd_data;
        resp_err_q  <= fault;
      end
    end
  end

  assign mem_resp_data = resp_data_q;
  assign mem_resp_err  = resp_err_q;

`ifdef LANE_MEM_RESPONDER_STATS_EN
  logic [31:0] rd_count, wr_count, err_count;
  logic        handshake;

  assign handshake = mem_resp_valid && mem_resp_ready;

  // Faulting accesses count only as errors; all counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (handshake) begin
      if (resp_err_q) begin
        if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
      end else if (write_q) begin
        if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
      end else begin
        if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      end
    end
  end

  assign stat_rd_count  = rd_count;
  assign stat_wr_count  = wr_count;
  assign stat_err_count = err_count;
`else
  assign stat_rd_count  = 32'd0;
  assign stat_wr_count  = 32'd0;
  assign stat_err_count = 32'd0;
`endif

endmodule

// File: doc/lane_mem_responder.md
Name: lane_mem_responder

Overview:
- Memory-side responder for the per-lane memory request/response protocol driven by the warp memory interface.
- Accepts one request at a time on a valid/ready request channel and performs a word read or write on an internal scratchpad after a configurable latency.
- Returns one response per request (loads and stores alike) on a valid/ready response channel.
- Serves as the on-chip scratchpad backing the lanes and as the bench memory model.

Parameters:
- DATA_WIDTH, warp_pkg::DATA_WIDTH (32), data word width in bits; byte addressing, BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, warp_pkg::ADDR_WIDTH (32), request byte-address width.
- MEM_WORDS, 1024, scratchpad depth in words; power of two.
- LATENCY, 2, access latency in cycles; legal range 1..15; elaboration error outside it.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_req_valid  in  1  request valid.
- mem_req_ready  out  1  responder can accept a request.
- mem_req_addr  in  ADDR_WIDTH  byte address.
- mem_req_write  in  1  1 = store, 0 = load.
- mem_req_data  in  DATA_WIDTH  store data.
- mem_resp_valid  out  1  response valid.
- mem_resp_ready  in  1  initiator accepts response.
- mem_resp_data  out  DATA_WIDTH  load data; 0 for stores and errors.
- mem_resp_err  out  1  response is for a faulting access.
- init_we  in  1  preload write strobe, usable in any state.
- init_idx  in  $clog2(MEM_WORDS)  preload word index.
- init_data  in  DATA_WIDTH  preload data.
- stat_rd_count  out  32  loads completed (optional feature).
- stat_wr_count  out  32  stores completed (optional feature).
- stat_err_count  out  32  faulting accesses (optional feature).

Behaviour:
- Reset values:
  - State RSP_IDLE.
  - mem_req_ready=1, mem_resp_valid=0, mem_resp_data=0, mem_resp_err=0.
  - Stat counters = 0.
  - Scratchpad contents are NOT reset and survive reset.
- FSM (typedef rsp_state_e):
  - RSP_IDLE: mem_req_ready=1. On valid&ready: latch addr, write, data; load cnt=LATENCY-1; go RSP_ACCESS.
  - RSP_ACCESS: mem_req_ready=0. If cnt!=0, decrement. If cnt==0, perform the access, register the response data and err, go RSP_RESPOND.
  - RSP_RESPOND: mem_resp_valid=1. Data and err are held stable until mem_resp_ready. On handshake go RSP_IDLE.
- Latency:
  - Request accepted in cycle T; mem_resp_valid first asserts in cycle T+1+LATENCY.
  - With mem_resp_ready held high, the next acceptance is at T+2+LATENCY.
  - One outstanding request maximum.
- Addressing:
  - idx = addr >> log2(BYTES).
  - Fault when addr[log2(BYTES)-1:0] != 0 (misaligned) or idx >= MEM_WORDS.
  - Fault handling: store is dropped, load returns 0, mem_resp_err=1.
- Store response: mem_resp_data=0, mem_resp_err=0 unless faulting.
- Store commit: array write happens in the RSP_ACCESS cycle with cnt==0, not at acceptance.
- Init port:
  - Writes array[init_idx] on init_we in any cycle.
  - Same-cycle collision with a committing store to the same word: the store wins.
  - A load committing in the same cycle as an init write to the same word returns the old value.
- mem_resp_ready high while not in RSP_RESPOND is ignored.
- mem_req_valid while not in RSP_IDLE is ignored; no acceptance.
- Reset mid-operation: immediately returns to RSP_IDLE. An in-flight store not yet committed is lost; no response is issued.

Optional Feature:
- Macro: LANE_MEM_RESPONDER_STATS_EN.
- Defined: stat counters increment by 1 at each response handshake, selected by type (load/store) or fault. A fault counts only in stat_err_count. Counters saturate at 32'hFFFF_FFFF.
- Undefined: stat ports are tied to 0 and no counter flops exist.

Decomposition:
- warp_pkg additions: rsp_state_e typedef; RSP_LATENCY_MAX=15 constant.
- DATA_WIDTH and ADDR_WIDTH come from warp_pkg.
- One sub-module, lane_mem_sram: behavioural MEM_WORDS x DATA_WIDTH array. It has one read port and two write ports (access, init) with access-port priority.

Test Plan:
- Preload idx 5 = 32'hCAFE0001; load addr 0x14 accepted at T -> mem_resp_valid at T+3 (LATENCY=2), data 32'hCAFE0001, err=0.
- Store 32'h12345678 to 0x40, then load 0x40 -> store response data 0 err 0; load returns 32'h12345678.
- Load 0x13 (misaligned) and load 0x1000 (MEM_WORDS=1024) -> each returns data 0, err=1. A store to 0x1000 leaves the array unchanged.
- Hold mem_resp_ready=0 for 5 cycles in RSP_RESPOND -> valid/data/err stable and mem_req_ready=0 throughout. Handshake on cycle 6; mem_req_ready=1 the next cycle.
- Assert rst_n=0 during RSP_ACCESS of a store to 0x8 -> outputs return to reset values, no response issued, array[2] unchanged; prior preload data still readable.
- With LANE_MEM_RESPONDER_STATS_EN, run 3 loads, 2 stores, 1 fault -> counters rd=3, wr=2, err=1.
